// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution datapath.
// Pixel and window layouts match proc_elem.img_in.
package conv_pkg;

    localparam int DEF_KERNEL_SIZE    = 3;
    localparam int DEF_PX_SIZE        = 8;
    localparam int DEF_INPUT_CHANNELS = 1;
    localparam int DEF_IMG_WIDTH      = 28;
    localparam int DEF_IMG_HEIGHT     = 28;

    typedef logic [DEF_INPUT_CHANNELS-1:0][DEF_PX_SIZE-1:0] pixel_t;

    typedef pixel_t [DEF_KERNEL_SIZE-1:0][DEF_KERNEL_SIZE-1:0] window_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/window_buffer_line_buffer.sv
// Fixed-depth row delay: tap is the word written DEPTH enables ago.
// Storage is deliberately not reset.
module line_buffer #(
    parameter int DEPTH = 28,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tap
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign tap = mem[DEPTH-1];

endmodule

// File: rtl/window_buffer.sv
// Streaming KxK sliding-window generator, valid windows only.
// Row r=K-1 of the window holds the newest image row.
module window_buffer
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE    = DEF_KERNEL_SIZE,
    parameter int PX_SIZE        = DEF_PX_SIZE,
    parameter int INPUT_CHANNELS = DEF_INPUT_CHANNELS,
    parameter int IMG_WIDTH      = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT     = DEF_IMG_HEIGHT
) (
    input  logic clk,
    input  logic rst,
    input  logic [INPUT_CHANNELS-1:0][PX_SIZE-1:0] in_px,
    input  logic in_valid,
    output logic in_ready,
    output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0]
                 [INPUT_CHANNELS-1:0][PX_SIZE-1:0] win_out,
    output logic out_valid,
    input  logic out_ready,
    output logic out_last
);

    localparam int CW = cnt_width(IMG_WIDTH);
    localparam int RW = cnt_width(IMG_HEIGHT);
    localparam int PW = INPUT_CHANNELS * PX_SIZE;

    typedef logic [INPUT_CHANNELS-1:0][PX_SIZE-1:0] px_t;
    typedef px_t [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0] win_t;

    if (KERNEL_SIZE < 2 || IMG_WIDTH < KERNEL_SIZE ||
        IMG_HEIGHT < KERNEL_SIZE) begin : g_bad_cfg
        $error("window_buffer: image smaller than kernel");
    end

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          accept;
    logic          emit;
    logic          last_px;
    px_t           tap [KERNEL_SIZE-1];
    win_t          win_q;
    win_t          win_nxt;

    assign in_ready = !rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign last_px  = (row == RW'(IMG_HEIGHT-1)) &&
                      (col == CW'(IMG_WIDTH-1));
    assign emit     = accept &&
                      (row >= RW'(KERNEL_SIZE-1)) &&
                      (col >= CW'(KERNEL_SIZE-1));

    // Cascade: delay j feeds delay j+1, so tap j is j+1 rows old.
    for (genvar j = 0; j < KERNEL_SIZE-1; j++) begin : g_lb
        px_t lb_din;
        if (j == 0) begin : g_first
            assign lb_din = in_px;
        end else begin : g_next
            assign lb_din = tap[j-1];
        end
        line_buffer #(
            .DEPTH(IMG_WIDTH),
            .WIDTH(PW)
        ) u_lb (
            .clk (clk),
            .en  (accept),
            .din (lb_din),
            .tap (tap[j])
        );
    end

    always_comb begin
        win_nxt = win_q;
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            for (int k = 0; k < KERNEL_SIZE-1; k++) begin
                win_nxt[r][k] = win_q[r][k+1];
            end
        end
        win_nxt[KERNEL_SIZE-1][KERNEL_SIZE-1] = in_px;
        for (int j = 0; j < KERNEL_SIZE-1; j++) begin
            win_nxt[KERNEL_SIZE-2-j][KERNEL_SIZE-1] = tap[j];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == CW'(IMG_WIDTH-1)) begin
                col <= '0;
                if (row == RW'(IMG_HEIGHT-1)) begin
                    row <= '0;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Window only moves on accept, which a stall blocks, so it
    // doubles as the held output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q <= '0;
        end else if (accept) begin
            win_q <= win_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_last  <= last_px;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign win_out = win_q;

endmodule

// File: tb/tb_window_buffer.sv
// Scoreboard bench for window_buffer: a 4x4 and a 28x28 instance,
// both K=3, 3 channels, checked against an image-array model.
module tb_window_buffer;

    localparam int K  = 3;
    localparam int P  = 8;
    localparam int C  = 3;
    localparam int W0 = 4;
    localparam int H0 = 4;
    localparam int W1 = 28;
    localparam int H1 = 28;

    typedef logic [C-1:0][P-1:0] px_t;
    typedef logic [K-1:0][K-1:0][C-1:0][P-1:0] win_t;
    typedef struct packed {
        logic inst;
        logic last;
        win_t w;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    px_t  in_px     [2];
    logic in_valid  [2];
    logic in_ready  [2];
    win_t win_out   [2];
    logic out_valid [2];
    logic out_ready [2];
    logic out_last  [2];

    int   checks = 0;
    int   errors = 0;
    exp_t sb [$];
    int   got   [2];
    int   lasts [2];
    int   mrow  [2];
    int   mcol  [2];
    logic lat_pend [2];
    px_t  img [2][H1][W1];
    int   rdy_mode = 0;
    int   gap_pct  = 0;

    always #5 clk = ~clk;

    window_buffer #(
        .KERNEL_SIZE(K), .PX_SIZE(P), .INPUT_CHANNELS(C),
        .IMG_WIDTH(W0), .IMG_HEIGHT(H0)
    ) dut_s (
        .clk(clk), .rst(rst),
        .in_px(in_px[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .win_out(win_out[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_last(out_last[0])
    );

    window_buffer #(
        .KERNEL_SIZE(K), .PX_SIZE(P), .INPUT_CHANNELS(C),
        .IMG_WIDTH(W1), .IMG_HEIGHT(H1)
    ) dut_l (
        .clk(clk), .rst(rst),
        .in_px(in_px[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .win_out(win_out[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_last(out_last[1])
    );

    function automatic int iw(input int i);
        return (i == 0) ? W0 : W1;
    endfunction

    function automatic int ih(input int i);
        return (i == 0) ? H0 : H1;
    endfunction

    function automatic void check(input string nm,
                                  input logic [255:0] act,
                                  input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endfunction

    // Consumer readiness pattern
    initial begin
        out_ready[0] = 1'b1;
        out_ready[1] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                case (rdy_mode)
                    0:       out_ready[i] = 1'b1;
                    1:       out_ready[i] = !out_ready[i];
                    default: out_ready[i] = ($urandom_range(0, 3) != 0);
                endcase
            end
        end
    end

    // Reference model: record accepted pixels into an image and
    // cut the expected window straight out of it.
    initial begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            mrow[i] = 0;
            mcol[i] = 0;
            lat_pend[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (lat_pend[i]) begin
                    check("latency_out_valid", out_valid[i], 1);
                    lat_pend[i] = 1'b0;
                end
                if (rst) begin
                    mrow[i] = 0;
                    mcol[i] = 0;
                end else if (in_valid[i] && in_ready[i]) begin
                    img[i][mrow[i]][mcol[i]] = in_px[i];
                    if (mrow[i] >= K-1 && mcol[i] >= K-1) begin
                        for (int r = 0; r < K; r++) begin
                            for (int k = 0; k < K; k++) begin
                                e.w[r][k] = img[i][mrow[i]-(K-1)+r]
                                               [mcol[i]-(K-1)+k];
                            end
                        end
                        e.inst = (i == 1);
                        e.last = (mrow[i] == ih(i)-1) &&
                                 (mcol[i] == iw(i)-1);
                        sb.push_back(e);
                        lat_pend[i] = 1'b1;
                    end
                    mcol[i]++;
                    if (mcol[i] == iw(i)) begin
                        mcol[i] = 0;
                        mrow[i] = (mrow[i] + 1) % ih(i);
                    end
                end
            end
        end
    end

    // Monitor: pop and compare on every output handshake
    initial begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            got[i]   = 0;
            lasts[i] = 0;
        end
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (out_valid[i] && !out_ready[i]) begin
                        check("stall_in_ready", in_ready[i], 0);
                    end
                    if (out_valid[i] && out_ready[i]) begin
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_window: inst %0d got %0h required none",
                                     i, win_out[i]);
                        end else begin
                            e = sb.pop_front();
                            check("window_inst", i, e.inst);
                            check("window", win_out[i], e.w);
                            check("out_last", out_last[i], e.last);
                            got[i]++;
                            if (out_last[i]) lasts[i]++;
                        end
                    end
                end
            end
        end
    end

    task automatic send_px(input int i, input px_t p);
        int n;
        n = 0;
        in_px[i]    = p;
        in_valid[i] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready[i] && n < 100);
        if (!in_ready[i]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: inst %0d got in_ready 0 required 1", i);
        end
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
        while ($urandom_range(0, 99) < gap_pct) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic small_frame(input int base, input int npx);
        px_t p;
        for (int idx = 0; idx < npx; idx++) begin
            for (int c = 0; c < C; c++) begin
                p[c] = 8'(base + 16*c + idx);
            end
            send_px(0, p);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid[0] || out_valid[1]) &&
               n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending required 0", sb.size());
        end
    endtask

    task automatic expect_counts(input string nm, input int i,
                                 input int g0, input int l0,
                                 input int nwin);
        check({nm, "_windows"}, got[i] - g0, nwin);
        check({nm, "_lasts"}, lasts[i] - l0, nwin / ((i == 0) ? 4 : 676));
    endtask

    initial begin
        int g0;
        int l0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0;
            in_px[i]    = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_in_ready", in_ready[i], 0);
            check("rst_out_valid", out_valid[i], 0);
            check("rst_out_last", out_last[i], 0);
            check("rst_win_out", win_out[i], 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        g0 = got[0]; l0 = lasts[0];
        small_frame(0, 16);
        drain();
        expect_counts("frame_ready_high", 0, g0, l0, 4);

        rdy_mode = 1;
        g0 = got[0]; l0 = lasts[0];
        small_frame(0, 16);
        drain();
        rdy_mode = 0;
        expect_counts("frame_ready_toggle", 0, g0, l0, 4);

        g0 = got[0]; l0 = lasts[0];
        small_frame(0, 16);
        small_frame(100, 16);
        drain();
        expect_counts("two_frames", 0, g0, l0, 8);

        g0 = got[0]; l0 = lasts[0];
        small_frame(50, 7);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", in_ready[0], 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_out_valid", out_valid[0], 0);
        check("midrst_in_ready2", in_ready[0], 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        small_frame(0, 16);
        drain();
        expect_counts("after_reset", 0, g0, l0, 4);

        gap_pct  = 50;
        rdy_mode = 2;
        g0 = got[1]; l0 = lasts[1];
        for (int n = 0; n < W1*H1; n++) begin
            send_px(1, px_t'($urandom));
        end
        rdy_mode = 0;
        drain();
        expect_counts("random_28x28", 1, g0, l0, 676);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
